// File: rtl/tqv_spi_reg_master.sv
// SPI mode-0 initiator: one register read/write command becomes one framed SPI transfer.
// Optional feature macro TQV_SPI_MASTER_WR_ACK_EN: also pulse o_rsp_valid at the end of write frames.

module tqv_spi_reg_master #(
    parameter int CLK_DIV  = 4,
    parameter int RD_DUMMY = 8,
    parameter int CS_GAP   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_rw,
    input  logic [5:0]  i_cmd_addr,
    input  logic [1:0]  i_cmd_width,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_busy,
    output logic        o_spi_cs_n,
    output logic        o_spi_clk,
    output logic        o_spi_mosi,
    input  logic        i_spi_miso
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HDR,
        ST_DUMMY,
        ST_DATA,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_div;
    logic        r_phase;
    logic [5:0]  r_bit;
    logic        r_rw;
    logic [1:0]  r_width;
    logic [40:0] r_tx;
    logic [31:0] r_rx;
    logic        r_cs_n;
    logic        r_sclk;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;

    logic        w_accept;
    logic        w_tick;
    logic        w_in_bits;
    logic        w_rise;
    logic        w_fall;
    logic        w_bit_last;
    logic [31:0] w_wdata_al;

    function automatic logic [5:0] len_m1(input logic [1:0] width);
        case (width)
            2'b00:   len_m1 = 6'd7;
            2'b01:   len_m1 = 6'd15;
            default: len_m1 = 6'd31;
        endcase
    endfunction

    function automatic logic [31:0] width_mask(input logic [1:0] width);
        case (width)
            2'b00:   width_mask = 32'h0000_00FF;
            2'b01:   width_mask = 32'h0000_FFFF;
            default: width_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_tick      = (r_state != ST_IDLE) && (r_div == 8'(CLK_DIV - 1));
    assign w_in_bits   = (r_state == ST_HDR) || (r_state == ST_DUMMY) || (r_state == ST_DATA);
    assign w_rise      = w_in_bits && w_tick && !r_phase;
    assign w_fall      = w_in_bits && w_tick && r_phase;
    assign w_bit_last  = w_fall && (r_bit == 6'd0);

    // Write data is left-aligned so it follows the header straight out of the top of r_tx;
    // reads load zeros, which gives mosi=0 through the dummy and read-data bits for free.
    always_comb begin
        w_wdata_al = 32'd0;
        if (i_cmd_rw) begin
            case (i_cmd_width)
                2'b00:   w_wdata_al = {i_cmd_wdata[7:0], 24'd0};
                2'b01:   w_wdata_al = {i_cmd_wdata[15:0], 16'd0};
                default: w_wdata_al = i_cmd_wdata;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_SETUP;
            ST_SETUP: if (w_tick) w_next = ST_HDR;
            ST_HDR: begin
                if (w_bit_last) begin
                    if (r_rw || (RD_DUMMY == 0)) w_next = ST_DATA;
                    else                         w_next = ST_DUMMY;
                end
            end
            ST_DUMMY: if (w_bit_last) w_next = ST_DATA;
            ST_DATA:  if (w_bit_last) w_next = ST_HOLD;
            ST_HOLD:  if (w_tick) w_next = ST_GAP;
            ST_GAP:   if (w_tick && (r_bit == 6'd0)) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Half-period timing, shifting and phase-entry counter loads; a later assignment in this
    // block intentionally overrides an earlier one on the same edge (e.g. counter reload on exit).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div       <= 8'd0;
            r_phase     <= 1'b0;
            r_bit       <= 6'd0;
            r_rw        <= 1'b0;
            r_width     <= 2'b00;
            r_tx        <= 41'd0;
            r_rx        <= 32'd0;
            r_cs_n      <= 1'b1;
            r_sclk      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b0;

            if ((r_state == ST_IDLE) || w_tick) r_div <= 8'd0;
            else                                r_div <= r_div + 8'd1;

            if (w_accept) begin
                r_rw    <= i_cmd_rw;
                r_width <= i_cmd_width;
                r_tx    <= {i_cmd_rw, i_cmd_width, i_cmd_addr, w_wdata_al};
                r_cs_n  <= 1'b0;
                r_phase <= 1'b0;
            end

            if (w_rise) begin
                r_sclk  <= 1'b1;
                r_phase <= 1'b1;
                if ((r_state == ST_DATA) && !r_rw) r_rx <= {r_rx[30:0], i_spi_miso};
            end

            if (w_fall) begin
                r_sclk  <= 1'b0;
                r_phase <= 1'b0;
                r_tx    <= {r_tx[39:0], 1'b0};
                r_bit   <= r_bit - 6'd1;
            end

            if ((r_state == ST_GAP) && w_tick) r_bit <= r_bit - 6'd1;

            if (w_next != r_state) begin
                case (w_next)
                    ST_HDR:   r_bit <= 6'd8;
                    ST_DUMMY: r_bit <= 6'(RD_DUMMY - 1);
                    ST_DATA:  r_bit <= len_m1(r_width);
                    ST_HOLD: begin
                        if (!r_rw) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= r_rx & width_mask(r_width);
                        end
`ifdef TQV_SPI_MASTER_WR_ACK_EN
                        else begin
                            r_rsp_valid <= 1'b1;
                        end
`else
`endif
                    end
                    ST_GAP: begin
                        r_cs_n <= 1'b1;
                        r_bit  <= 6'(CS_GAP - 1);
                    end
                    ST_IDLE:  r_bit <= 6'd0;
                    default:  ;
                endcase
            end
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_spi_cs_n  = r_cs_n;
    assign o_spi_clk   = r_sclk;
    assign o_spi_mosi  = r_tx[40];

endmodule

// File: tb/tb_tqv_spi_reg_master.sv
// Scoreboard bench for tqv_spi_reg_master: random and directed commands, an SPI responder,
// and monitors comparing frames, responses and busy length against a frame-level model.

module tb_tqv_spi_reg_master;

    localparam int CLK_DIV  = 4;
    localparam int RD_DUMMY = 8;
    localparam int CS_GAP   = 2;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdRw;
    logic [5:0]  cmdAddr;
    logic [1:0]  cmdWidth;
    logic [31:0] cmdWdata;
    logic        rspValid;
    logic [31:0] rspRdata;
    logic        busy;
    logic        spiCsN;
    logic        spiClk;
    logic        spiMosi;
    logic        spiMiso;

    typedef struct {
        logic        rw;
        logic [5:0]  addr;
        logic [1:0]  width;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] expHeld;
    } cmd_t;

    cmd_t        expFrame[$];
    logic [31:0] expRsp[$];
    int          expBusy[$];
    logic [31:0] lastRead;

    int compared = 0;
    int mismatched = 0;

    cmd_t        curCmd;
    logic [63:0] actBits;
    int          actCount;
    int          busyCycles;
    int          csHigh;
    bit          frameSeen;
    logic        prevMosi;

    tqv_spi_reg_master #(
        .CLK_DIV  (CLK_DIV),
        .RD_DUMMY (RD_DUMMY),
        .CS_GAP   (CS_GAP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_cmd_valid (cmdValid),
        .o_cmd_ready (cmdReady),
        .i_cmd_rw    (cmdRw),
        .i_cmd_addr  (cmdAddr),
        .i_cmd_width (cmdWidth),
        .i_cmd_wdata (cmdWdata),
        .o_rsp_valid (rspValid),
        .o_rsp_rdata (rspRdata),
        .o_busy      (busy),
        .o_spi_cs_n  (spiCsN),
        .o_spi_clk   (spiClk),
        .o_spi_mosi  (spiMosi),
        .i_spi_miso  (spiMiso)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, required);
        end
    endtask

    function automatic int lenOf(input logic [1:0] width);
        if (width == 2'd0) return 8;
        if (width == 2'd1) return 16;
        return 32;
    endfunction

    function automatic int busyOf(input cmd_t c);
        int dummy;
        dummy = c.rw ? 0 : RD_DUMMY;
        return 2 * CLK_DIV * (9 + lenOf(c.width) + dummy) + CLK_DIV * (2 + CS_GAP);
    endfunction

    // Expected mosi stream as seen at each rising sclk, packed MSB-first into a 64-bit value.
    function automatic logic [63:0] expectedBits(input cmd_t c, output int count);
        logic [63:0] v;
        int          hdr;
        int          len;
        v     = '0;
        count = 0;
        len   = lenOf(c.width);
        hdr   = int'(c.rw) * 256 + int'(c.width) * 64 + int'(c.addr);
        for (int i = 8; i >= 0; i--) begin
            v = {v[62:0], ((hdr >> i) & 1) == 1};
            count++;
        end
        if (c.rw) begin
            for (int i = len - 1; i >= 0; i--) begin
                v = {v[62:0], c.wdata[i]};
                count++;
            end
        end else begin
            for (int i = 0; i < RD_DUMMY + len; i++) begin
                v = {v[62:0], 1'b0};
                count++;
            end
        end
        return v;
    endfunction

    function automatic cmd_t makeCmd(input logic rw, input logic [5:0] addr, input logic [1:0] width,
                                     input logic [31:0] wdata, input logic [31:0] rdata);
        cmd_t c;
        c.rw      = rw;
        c.addr    = addr;
        c.width   = width;
        c.wdata   = wdata;
        c.rdata   = rdata;
        c.expHeld = '0;
        return c;
    endfunction

    function automatic cmd_t randCmd();
        return makeCmd(1'($urandom), 6'($urandom), 2'($urandom), $urandom, $urandom);
    endfunction

    task automatic modelIssue(input cmd_t c);
        cmd_t        m;
        logic [63:0] full;
        m = c;
        if (!c.rw) begin
            full     = 64'(c.rdata) % (64'd1 << lenOf(c.width));
            lastRead = full[31:0];
            expRsp.push_back(lastRead);
        end
`ifdef TQV_SPI_MASTER_WR_ACK_EN
        if (c.rw) expRsp.push_back(lastRead);
`endif
        m.expHeld = lastRead;
        expFrame.push_back(m);
        expBusy.push_back(busyOf(c));
    endtask

    task automatic applyStimulus(input cmd_t c, input bit keepValid);
        int guard;
        @(negedge clk);
        cmdRw    = c.rw;
        cmdAddr  = c.addr;
        cmdWidth = c.width;
        cmdWdata = c.wdata;
        cmdValid = 1'b1;
        guard    = 0;
        while (cmdReady !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cmdReady !== 1'b1) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            cmdValid = 1'b0;
            return;
        end
        modelIssue(c);
        @(posedge clk);
        #1;
        if (!keepValid) cmdValid = 1'b0;
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (busy !== 1'b0) checkOutput("idle_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Responder: present the next miso bit after each falling sclk, keyed on rises seen so far.
    task automatic driveMiso();
        int k;
        int len;
        len = lenOf(curCmd.width);
        k   = actCount - 9 - (curCmd.rw ? 0 : RD_DUMMY);
        if (!curCmd.rw && k >= 0 && k < len) spiMiso = curCmd.rdata[len - 1 - k];
        else                                 spiMiso = 1'($urandom);
    endtask

    always @(negedge spiCsN) begin
        actBits  = '0;
        actCount = 0;
        if (expFrame.size() > 0) curCmd = expFrame[0];
        driveMiso();
    end

    always @(posedge spiClk) begin
        if (spiCsN === 1'b0) begin
            actBits = {actBits[62:0], spiMosi};
            actCount++;
        end
    end

    always @(negedge spiClk) begin
        if (spiCsN === 1'b0) driveMiso();
    end

    always @(posedge spiCsN) begin
        cmd_t        c;
        logic [63:0] expV;
        int          expN;
        if (rstN === 1'b1) begin
            if (expFrame.size() == 0) begin
                checkOutput("frame_unexpected", 64'd1, 64'd0);
            end else begin
                c    = expFrame.pop_front();
                expV = expectedBits(c, expN);
                checkOutput("sclk_rises", 64'(actCount), 64'(expN));
                checkOutput("mosi_bits", actBits, expV);
                checkOutput("rdata_held", 64'(rspRdata), 64'(c.expHeld));
            end
        end
    end

    always @(negedge clk) begin
        if (rstN === 1'b1 && rspValid === 1'b1) begin
            if (expRsp.size() == 0) checkOutput("rsp_unexpected", 64'd1, 64'd0);
            else                    checkOutput("rsp_rdata", 64'(rspRdata), 64'(expRsp.pop_front()));
        end
    end

    // Busy length, chip-select gap and mosi-only-while-sclk-low checks, all sampled mid-cycle.
    always @(negedge clk) begin
        if (rstN !== 1'b1) begin
            busyCycles = 0;
            csHigh     = 0;
            frameSeen  = 1'b0;
        end else begin
            if (busy === 1'b1) begin
                busyCycles++;
            end else if (busyCycles > 0) begin
                if (expBusy.size() == 0) checkOutput("busy_unexpected", 64'(busyCycles), 64'd0);
                else                     checkOutput("busy_clks", 64'(busyCycles), 64'(expBusy.pop_front()));
                busyCycles = 0;
            end
            if (spiCsN === 1'b1) begin
                csHigh++;
            end else begin
                if (frameSeen && csHigh > 0) begin
                    compared++;
                    if (csHigh < CS_GAP * CLK_DIV) begin
                        mismatched++;
                        $display("[TB] FAIL cs_gap: got %0d clks required >= %0d", csHigh, CS_GAP * CLK_DIV);
                    end
                end
                frameSeen = 1'b1;
                csHigh    = 0;
            end
            if (spiMosi !== prevMosi) checkOutput("mosi_change_sclk", 64'(spiClk), 64'd0);
        end
        prevMosi = spiMosi;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cmdValid = 1'b0;
        cmdRw    = 1'b0;
        cmdAddr  = '0;
        cmdWidth = '0;
        cmdWdata = '0;
        spiMiso  = 1'b0;
        lastRead = '0;
        prevMosi = 1'b0;
        rstN     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_cmd_ready", 64'(cmdReady), 64'd1);
        checkOutput("reset_rsp_valid", 64'(rspValid), 64'd0);
        checkOutput("reset_rsp_rdata", 64'(rspRdata), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_cs_n", 64'(spiCsN), 64'd1);
        checkOutput("reset_sclk", 64'(spiClk), 64'd0);
        checkOutput("reset_mosi", 64'(spiMosi), 64'd0);
        rstN = 1'b1;

        $display("[TB] directed write and reads");
        applyStimulus(makeCmd(1'b1, 6'h05, 2'b10, 32'hDEADBEEF, 32'h0), 1'b0);
        waitIdle();
        applyStimulus(makeCmd(1'b0, 6'h3F, 2'b00, 32'h0, 32'h0000_00A5), 1'b0);
        waitIdle();
        applyStimulus(makeCmd(1'b0, 6'($urandom), 2'b11, 32'h0, $urandom), 1'b0);
        waitIdle();

        $display("[TB] back-to-back commands with valid held");
        applyStimulus(makeCmd(1'b1, 6'($urandom), 2'b01, $urandom, 32'h0), 1'b1);
        applyStimulus(makeCmd(1'b0, 6'($urandom), 2'b01, 32'h0, $urandom), 1'b0);
        waitIdle();

        $display("[TB] random commands");
        for (int i = 0; i < 10; i++) applyStimulus(randCmd(), 1'b0);
        waitIdle();

        $display("[TB] reset during a read frame");
        applyStimulus(makeCmd(1'b0, 6'h2A, 2'b00, 32'h0, 32'h0000_005A), 1'b0);
        begin
            int guard;
            guard = 0;
            while (actCount < 20 && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (actCount < 20) checkOutput("rise20_timeout", 64'd0, 64'd1);
        end
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("abort_cs_n", 64'(spiCsN), 64'd1);
        checkOutput("abort_sclk", 64'(spiClk), 64'd0);
        checkOutput("abort_mosi", 64'(spiMosi), 64'd0);
        checkOutput("abort_rsp_valid", 64'(rspValid), 64'd0);
        expFrame.delete();
        expRsp.delete();
        expBusy.delete();
        lastRead = '0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 4; i++) applyStimulus(randCmd(), 1'b0);
        applyStimulus(makeCmd(1'b0, 6'h11, 2'b10, 32'h0, $urandom), 1'b0);
        waitIdle();

        checkOutput("rsp_queue_drained", 64'(expRsp.size()), 64'd0);
        checkOutput("frame_queue_drained", 64'(expFrame.size()), 64'd0);
        checkOutput("busy_queue_drained", 64'(expBusy.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
